// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: drives every vector into a combinational block, holds it
// for SETTLE cycles, samples the response and scores it against a golden table.
module truth_table_sweeper #(
  parameter int IN_W = 3,
  parameter int OUT_W = 1,
  parameter int SETTLE = 1,
  parameter logic [OUT_W*(2**IN_W)-1:0] EXPECT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    err_count,
  output logic [IN_W-1:0]  first_fail,
  output logic             sample_valid,
  output logic [IN_W-1:0]  sample_idx,
  output logic [OUT_W-1:0] sample_resp,
  output logic             sample_ok
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  // With no settle time every vector goes straight to its sample cycle.
  localparam state_t          VEC_ENTRY   = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
  localparam logic [IN_W-1:0] LAST_IDX    = {IN_W{1'b1}};
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE);
  localparam logic [IN_W:0]   ERR_SAT     = {(IN_W+1){1'b1}};

  state_t           state, state_next;
  logic [7:0]       settle_cnt;
  logic             start_ok, is_last, match;
  logic [OUT_W-1:0] expect_entry;
  logic [IN_W:0]    err_next;

  always_comb begin
    start_ok     = start && (state == S_IDLE || state == S_DONE);
    is_last      = (stim == LAST_IDX);
    expect_entry = EXPECT[int'(stim)*OUT_W +: OUT_W];
    match        = (resp == expect_entry);
    err_next     = err_count;
    if (!match && err_count != ERR_SAT)
      err_next = err_count + 1'b1;
  end

  // Abort outranks start; termination is by index compare so the last vector is always tested.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_next = VEC_ENTRY;
        S_WAIT:   if (settle_cnt <= 8'd1) state_next = S_SAMPLE;
        S_SAMPLE: state_next = is_last ? S_DONE : VEC_ENTRY;
        S_DONE:   if (start) state_next = VEC_ENTRY;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Abort keeps err_count/first_fail so the partial result can still be inspected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      first_fail   <= '0;
      settle_cnt   <= '0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_resp  <= '0;
      sample_ok    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        done <= 1'b0;
        pass <= 1'b0;
        stim <= '0;
      end else if (start_ok) begin
        stim       <= '0;
        err_count  <= '0;
        first_fail <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
        busy       <= 1'b1;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == S_WAIT) begin
        settle_cnt <= settle_cnt - 8'd1;
      end else if (state == S_SAMPLE) begin
        sample_valid <= 1'b1;
        sample_idx   <= stim;
        sample_resp  <= resp;
        sample_ok    <= match;
        err_count    <= err_next;
        settle_cnt   <= SETTLE_LOAD;
        if (!match && err_count == '0)
          first_fail <= stim;
        if (is_last) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_next == '0);
        end else begin
          stim <= stim + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=0) sweeping an
// XOR block with a random fault mask, scored against a table-level reference model.
module tb_truth_table_sweeper;

  localparam logic [7:0] XOR_TABLE = 8'b1001_0110;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fault_mask;
  logic       sel;
  int         checks = 0;
  int         errors = 0;

  logic       start_a, abort_a, start_b, abort_b;
  logic [2:0] stim_a, stim_b, ff_a, ff_b, sidx_a, sidx_b;
  logic [3:0] err_a, err_b;
  logic       resp_a, resp_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic       sv_a, sv_b, sresp_a, sresp_b, sok_a, sok_b;

  // The block under sweep is a 3-input XOR with selected vectors inverted.
  assign resp_a = (^stim_a) ^ fault_mask[stim_a];
  assign resp_b = (^stim_b) ^ fault_mask[stim_b];

  logic [2:0] m_stim, m_ff, m_sidx;
  logic [3:0] m_err;
  logic       m_busy, m_done, m_pass, m_sv, m_sresp, m_sok;
  assign m_stim  = sel ? stim_b  : stim_a;
  assign m_ff    = sel ? ff_b    : ff_a;
  assign m_sidx  = sel ? sidx_b  : sidx_a;
  assign m_err   = sel ? err_b   : err_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_pass  = sel ? pass_b  : pass_a;
  assign m_sv    = sel ? sv_b    : sv_a;
  assign m_sresp = sel ? sresp_b : sresp_a;
  assign m_sok   = sel ? sok_b   : sok_a;

  truth_table_sweeper #(.IN_W(3), .OUT_W(1), .SETTLE(1), .EXPECT(XOR_TABLE)) dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a),
    .sample_valid(sv_a), .sample_idx(sidx_a), .sample_resp(sresp_a), .sample_ok(sok_a));

  truth_table_sweeper #(.IN_W(3), .OUT_W(1), .SETTLE(0), .EXPECT(XOR_TABLE)) dut0 (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b),
    .sample_valid(sv_b), .sample_idx(sidx_b), .sample_resp(sresp_b), .sample_ok(sok_b));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Reference: vector i is expected to read parity(i); it fails exactly where the mask is set.
  function automatic logic modelResp(input int i, input logic [7:0] mask);
    return logic'($countones(i) % 2) ^ mask[i];
  endfunction

  task automatic applyStimulus(input logic [7:0] mask, input int settle, input bit poke);
    int  cyc, k, exp_err, exp_ff;
    bit  seen;
    fault_mask = mask;
    exp_err = 0; exp_ff = 0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        exp_err++;
        if (!seen) begin exp_ff = i; seen = 1; end
      end
    end
    @(negedge clk); setStart(1'b1);
    @(negedge clk); setStart(1'b0);
    checkOutput("start_busy", m_busy, 1);
    checkOutput("start_done_clear", m_done, 0);
    checkOutput("start_stim", m_stim, 0);
    checkOutput("start_err_clear", m_err, 0);
    cyc = 0; k = 0;
    while (!m_done && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      setStart(poke && cyc == 3);
      if (m_sv) begin
        if (k < 8) begin
          checkOutput("sample_idx", m_sidx, k);
          checkOutput("sample_resp", m_sresp, modelResp(k, mask));
          checkOutput("sample_ok", m_sok, !mask[k]);
        end else begin
          checkOutput("sample_extra", k, 7);
        end
        k++;
      end
    end
    setStart(1'b0);
    checkOutput("sweep_cycles", cyc, 8 * (settle + 1));
    checkOutput("sample_count", k, 8);
    checkOutput("end_done", m_done, 1);
    checkOutput("end_busy", m_busy, 0);
    checkOutput("end_stim", m_stim, 7);
    checkOutput("end_err_count", m_err, exp_err);
    checkOutput("end_first_fail", m_ff, exp_ff);
    checkOutput("end_pass", m_pass, exp_err == 0);
  endtask

  task automatic waitStim(input logic [2:0] target);
    int n = 0;
    while (!(m_busy && m_stim == target) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) checkOutput("wait_stim_timeout", n, 0);
  endtask

  initial begin
    logic [7:0] m;
    int exp_err, exp_ff;
    bit seen;
    rst = 1'b1; sel = 1'b0; fault_mask = '0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    #12;
    checkOutput("reset_a", {stim_a, busy_a, done_a, pass_a, err_a, ff_a, sv_a, sidx_a, sresp_a, sok_a}, 0);
    checkOutput("reset_b", {stim_b, busy_b, done_b, pass_b, err_b, ff_b, sv_b, sidx_b, sresp_b, sok_b}, 0);
    @(negedge clk); rst = 1'b0;

    // Clean sweep, then stuck-at-0 restarted from DONE with a start pulse while busy.
    applyStimulus(8'h00, 1, 0);
    applyStimulus(XOR_TABLE, 1, 1);
    applyStimulus(8'hFF, 1, 0);
    for (int r = 0; r < 3; r++) applyStimulus(8'($urandom_range(0, 255)), 1, 0);

    sel = 1'b1;
    #1;
    applyStimulus(8'h00, 0, 0);
    applyStimulus(8'($urandom_range(0, 255)), 0, 1);
    sel = 1'b0;
    #1;

    // Abort during vector 5 keeps the score of vectors 0..4.
    m = 8'($urandom_range(0, 255));
    fault_mask = m;
    exp_err = 0; exp_ff = 0; seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        exp_err++;
        if (!seen) begin exp_ff = i; seen = 1; end
      end
    end
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    waitStim(3'd5);
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_done", done_a, 0);
    checkOutput("abort_stim", stim_a, 0);
    checkOutput("abort_err_kept", err_a, exp_err);
    checkOutput("abort_ff_kept", ff_a, exp_ff);
    applyStimulus(8'h00, 1, 0);

    // Abort landing on the final sample edge suppresses done.
    fault_mask = 8'h00;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    waitStim(3'd7);
    @(negedge clk); abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    checkOutput("abort_last_done", done_a, 0);
    checkOutput("abort_last_busy", busy_a, 0);
    checkOutput("abort_last_pass", pass_a, 0);
    checkOutput("abort_last_stim", stim_a, 0);

    // Asynchronous reset mid-sweep, away from any clock edge.
    fault_mask = 8'h24;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    waitStim(3'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_a", {stim_a, busy_a, done_a, pass_a, err_a, ff_a, sv_a, sidx_a, sresp_a, sok_a}, 0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(8'h00, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
